// File: rtl/ex_mem_elastic.sv
// ex_mem_elastic: elastic EX/MEM pipeline register, 2-entry (main + skid) with flush, bubble gating and stall counter
// Clk/Reset/Flush: falling-edge clock, sync active-high reset, squash of held entries
// E_*: EX-side payload with E_Valid/E_Ready handshake
// M_*: MEM-side payload of main entry with M_Valid/M_Ready handshake; M_Rw, M_Ctrl, M_Overflow zeroed on a bubble
// Stall_Cnt: saturating count of edges where MEM held back a valid entry
module ex_mem_elastic #(
  parameter int DATA_W = 32,
  parameter int RW_W   = 5,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              E_Valid,
  output logic              E_Ready,
  input  logic [DATA_W-1:0] E_Jtarg,
  input  logic [DATA_W-1:0] E_Btarg,
  input  logic [DATA_W-1:0] E_ALUout,
  input  logic [DATA_W-1:0] E_busB,
  input  logic              E_Zero,
  input  logic              E_Overflow,
  input  logic [RW_W-1:0]   E_Rw,
  input  logic [CTRL_W-1:0] E_Ctrl,
  output logic              M_Valid,
  input  logic              M_Ready,
  output logic [DATA_W-1:0] M_Jtarg,
  output logic [DATA_W-1:0] M_Btarg,
  output logic [DATA_W-1:0] M_ALUout,
  output logic [DATA_W-1:0] M_busB,
  output logic              M_Zero,
  output logic              M_Overflow,
  output logic [RW_W-1:0]   M_Rw,
  output logic [CTRL_W-1:0] M_Ctrl,
  output logic [CNT_W-1:0]  Stall_Cnt
);
  localparam int PW = 4*DATA_W + 2 + RW_W + CTRL_W;
  logic [PW-1:0] in_p, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic push, pop, load_main, m_ovf;
  logic [RW_W-1:0] m_rw;
  logic [CTRL_W-1:0] m_ctl;
  assign in_p = {E_Jtarg, E_Btarg, E_ALUout, E_busB, E_Zero, E_Overflow, E_Rw, E_Ctrl};
  assign E_Ready = !skid_v_q;
  assign push = E_Valid & E_Ready;
  assign pop = main_v_q & M_Ready;
  // main is refilled whenever it is free this edge; skid has priority to keep FIFO order
  assign load_main = !main_v_q | pop;
  always_comb begin
    main_v_d = load_main ? (skid_v_q | push) : 1'b1;
    main_d = (load_main & (skid_v_q | push)) ? (skid_v_q ? skid_q : in_p) : main_q;
    skid_v_d = skid_v_q ? !pop : (push & !load_main);
    skid_d = (push & !load_main) ? in_p : skid_q;
    cnt_d = (main_v_q & !M_Ready & !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(negedge Clk) begin
    if (Reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
      cnt_q <= '0;
    end else if (Flush) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
      cnt_q <= cnt_d;
    end
  end
  assign {M_Jtarg, M_Btarg, M_ALUout, M_busB, M_Zero, m_ovf, m_rw, m_ctl} = main_q;
  assign M_Valid = main_v_q;
  assign M_Overflow = main_v_q ? m_ovf : 1'b0;
  assign M_Rw = main_v_q ? m_rw : '0;
  assign M_Ctrl = main_v_q ? m_ctl : '0;
  assign Stall_Cnt = cnt_q;
endmodule

// File: doc/ex_mem_elastic.md
Name: ex_mem_elastic

Overview:
- Next-generation EX/MEM stage register for the 5-stage pipeline: an elastic, parametrised pipeline register with a valid/ready handshake.
- It holds a 2-entry buffer (main plus skid), so MEM back-pressure never drops an EX result.
- Supports flush (branch/jump/exception squash), gates write-side outputs when the stage is empty, and keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, width of Jtarg, Btarg, ALUout, busB
- RW_W, 5, width of destination register index Rw
- CTRL_W, 4, width of opaque control bundle passed EX->MEM (MemWr, MemtoReg, RegWr, etc.)
- CNT_W, 16, width of stall counter

Ports:
- Clk  in  1  pipeline clock; all state updates on falling edge
- Reset  in  1  synchronous, active-high, sampled on falling edge of Clk
- Flush  in  1  squash all held entries; sampled on falling edge
- E_Valid  in  1  EX presents a valid result
- E_Ready  out  1  stage can accept an entry this edge
- E_Jtarg, E_Btarg, E_ALUout, E_busB  in  DATA_W each  EX payload
- E_Zero, E_Overflow  in  1 each  ALU flags
- E_Rw  in  RW_W  destination register
- E_Ctrl  in  CTRL_W  control bundle
- M_Valid  out  1  main entry valid
- M_Ready  in  1  MEM consumes main entry this edge
- M_Jtarg, M_Btarg, M_ALUout, M_busB  out  DATA_W each  payload of main entry
- M_Zero, M_Overflow  out  1 each  flags of main entry (M_Overflow gated, see below)
- M_Rw  out  RW_W  destination of main entry (gated)
- M_Ctrl  out  CTRL_W  control of main entry (gated)
- Stall_Cnt  out  CNT_W  saturating back-pressure counter

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high. All registers update on the falling edge of Clk.
- Storage: main entry (drives M_*) and skid entry. Each entry holds the full payload plus a valid bit.
- Occupancy states:
  - EMPTY: no valid entries.
  - ONE: main valid only.
  - FULL: main and skid both valid.
- Handshake signals:
  - E_Ready = !skid_valid. It is a registered-state function with no combinational path from M_Ready.
  - M_Valid = main_valid.
  - push = E_Valid & E_Ready.
  - pop = M_Valid & M_Ready.
- Transitions when Flush=0:
  - EMPTY: push -> ONE, payload loaded into main.
  - ONE: push&pop -> ONE, main replaced by new payload. push&!pop -> FULL, payload into skid. !push&pop -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, skid moves to main and skid is invalidated. push is impossible (E_Ready=0). !pop -> hold.
- Ordering: strict FIFO. An entry is never overwritten while valid and not popped.
- Flush=1 at an edge: both valid bits cleared -> EMPTY. A simultaneous push is discarded. Payload registers may keep stale data.
- Output gating:
  - M_Rw = 0 when !M_Valid.
  - M_Ctrl = 0 when !M_Valid.
  - M_Overflow = 0 when !M_Valid.
  - This ensures a bubble writes nothing and raises no exception.
  - Other M_* outputs show the raw main payload.
- Latency: 1 falling edge from push to M_Valid when EMPTY. Throughput is 1 entry per edge when M_Ready is held high.
- Stall_Cnt:
  - Increments on each edge where M_Valid & !M_Ready & !Flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by Reset.
- Reset=1 at an edge:
  - Both valid bits = 0, so E_Ready=1 and M_Valid=0.
  - All payload registers = 0, so every M_* output = 0.
  - Stall_Cnt = 0.
  - Reset overrides Flush and push. Reset mid-FULL discards both entries.
- Width: no arithmetic on the payload. All fields pass through unmodified.

Test Plan:
- Reset then idle: after Reset, M_Valid=0, E_Ready=1, M_Rw=0, Stall_Cnt=0. Holding E_Valid=0 for 5 edges leaves the state unchanged.
- Streaming: M_Ready=1; push ALUout=0x10,0x20,0x30 with Rw=3,4,5 on consecutive edges -> each appears on M_* exactly 1 edge later, in order, with E_Ready constantly 1.
- Back-pressure: M_Ready=0; push A(ALUout=0xA) then B(0xB) -> after the 2nd edge E_Ready=0, M_ALUout=0xA. Raise M_Ready -> next edge M_ALUout=0xB, following edge M_Valid=0. Stall_Cnt equals the number of stalled edges.
- Flush with push: state FULL, assert Flush together with E_Valid (new Rw=7) -> next edge M_Valid=0, M_Rw=0, M_Ctrl=0, E_Ready=1. The new entry is not seen.
- Bubble gating: after popping the last entry, E_Overflow=1 is held in main but M_Valid=0 -> M_Overflow=0 and M_Rw=0.
- Counter saturation (CNT_W=3): hold a valid entry with M_Ready=0 for 10 edges -> Stall_Cnt=7 and stays at 7.
